// File: rtl/div_seq_param.sv
// Sequential non-restoring divider, signed or unsigned per operation.
// One result per accepted request; divide-by-zero and signed overflow short-circuit to DONE.
module div_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             in_ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div0,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic                    accept;
    logic                    is_div0;
    logic                    is_ovf;
    logic                    dvd_neg_in;
    logic                    dvs_neg_in;
    logic [WIDTH-1:0]        dvd_abs;
    logic [WIDTH-1:0]        dvs_abs;

    logic signed [WIDTH:0]   p;
    logic signed [WIDTH:0]   p_shift;
    logic signed [WIDTH:0]   p_step;
    logic signed [WIDTH:0]   p_fix;
    logic signed [WIDTH:0]   d_ext;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        d;
    logic [CW-1:0]           cnt;
    logic                    dvd_neg;
    logic                    q_neg;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        accept     = start && in_ready;
        is_div0    = (divisor == '0);
        is_ovf     = signed_op && (dividend == MIN_VAL) && (divisor == '1);
        dvd_neg_in = signed_op && dividend[WIDTH-1];
        dvs_neg_in = signed_op && divisor[WIDTH-1];
        dvd_abs    = dvd_neg_in ? negate(dividend) : dividend;
        dvs_abs    = dvs_neg_in ? negate(divisor) : divisor;
    end

    // P only needs WIDTH+1 bits: the shifted value may wrap, but the result of
    // the add/subtract always lands back in [-D, D) so the modular sum is exact.
    always_comb begin
        d_ext   = {1'b0, d};
        p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
        p_step  = p[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
        p_fix   = p[WIDTH] ? (p + d_ext) : p;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE, DONE: begin
                in_ready = 1'b1;
                valid    = (state == DONE);
                if (accept) state_next = (is_div0 || is_ovf) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quot     <= '0;
            rem      <= '0;
            div0     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        div0     <= is_div0;
                        overflow <= is_ovf && !is_div0;
                        dvd_neg  <= dvd_neg_in;
                        q_neg    <= dvd_neg_in ^ dvs_neg_in;
                        d        <= dvs_abs;
                        q        <= dvd_abs;
                        p        <= '0;
                        cnt      <= '0;
                        if (is_div0) begin
                            quot <= '1;
                            rem  <= dividend;
                        end else if (is_ovf) begin
                            quot <= MIN_VAL;
                            rem  <= '0;
                        end
                    end
                end
                CALC: begin
                    p   <= p_step;
                    q   <= {q[WIDTH-2:0], ~p_step[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    quot <= q_neg ? negate(q) : q;
                    rem  <= dvd_neg ? negate(p_fix[WIDTH-1:0]) : p_fix[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
// Directed and small random checks for div_seq_param at WIDTH=32 and WIDTH=8.
module tb_div_seq_param;

    logic        clk = 1'b0;
    logic        reset;

    logic        start32, sop32;
    logic [31:0] dvd32, dvs32, quot32, rem32;
    logic        rdy32, busy32, valid32, div0_32, ovf32;

    logic        start8, sop8;
    logic [7:0]  dvd8, dvs8, quot8, rem8;
    logic        rdy8, busy8, valid8, div0_8, ovf8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_seq_param #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .signed_op(sop32),
        .dividend(dvd32), .divisor(dvs32), .in_ready(rdy32), .busy(busy32),
        .valid(valid32), .quot(quot32), .rem(rem32), .div0(div0_32), .overflow(ovf32)
    );

    div_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_op(sop8),
        .dividend(dvd8), .divisor(dvs8), .in_ready(rdy8), .busy(busy8),
        .valid(valid8), .quot(quot8), .rem(rem8), .div0(div0_8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issues one request and returns the number of rising edges, accept edge
    // included, until valid is seen (capped at 100).
    task automatic run32(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic v_after_accept);
        sop32 = sop; dvd32 = a; dvs32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        edges = 1;
        v_after_accept = valid32;
        while (!valid32 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run8(input logic sop, input logic [7:0] a, input logic [7:0] b);
        int edges, ai, bi, qi, ri, exp_lat;
        logic [7:0] eq, er, recon;
        logic ediv0, eovf;
        sop8 = sop; dvd8 = a; dvs8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 1;
        while (!valid8 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        ediv0 = 1'b0; eovf = 1'b0;
        if (b == 8'h00) begin
            eq = 8'hFF; er = a; ediv0 = 1'b1;
        end else if (sop && a == 8'h80 && b == 8'hFF) begin
            eq = 8'h80; er = 8'h00; eovf = 1'b1;
        end else begin
            if (sop) begin
                ai = int'($signed(a)); bi = int'($signed(b));
            end else begin
                ai = int'({24'd0, a}); bi = int'({24'd0, b});
            end
            qi = ai / bi; ri = ai % bi;
            eq = qi[7:0]; er = ri[7:0];
        end
        exp_lat = (ediv0 || eovf) ? 1 : 10;
        check("w8_lat", 64'(edges), 64'(exp_lat));
        check("w8_quot", 64'(quot8), 64'(eq));
        check("w8_rem", 64'(rem8), 64'(er));
        check("w8_flags", 64'({div0_8, ovf8}), 64'({ediv0, eovf}));
        if (!ediv0) begin
            recon = quot8 * b + rem8;
            check("w8_identity", 64'(recon), 64'(a));
        end
    endtask

    initial begin
        int edges;
        logic va;
        reset = 1'b1;
        start32 = 1'b0; sop32 = 1'b0; dvd32 = '0; dvs32 = '0;
        start8 = 1'b0; sop8 = 1'b0; dvd8 = '0; dvs8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(rdy32), 64'(1));
        check("rst_busy", 64'(busy32), 64'(0));
        check("rst_valid", 64'(valid32), 64'(0));
        check("rst_flags", 64'({div0_32, ovf32}), 64'(0));
        check("rst_quot", 64'(quot32), 64'(0));
        check("rst_rem", 64'(rem32), 64'(0));
        reset = 1'b0;

        // 100/7 unsigned: valid after 33 edges following the accept edge.
        run32(1'b0, 32'd100, 32'd7, edges, va);
        check("u100_7_lat", 64'(edges), 64'(34));
        check("u100_7_quot", 64'(quot32), 64'(14));
        check("u100_7_rem", 64'(rem32), 64'(2));
        check("u100_7_flags", 64'({div0_32, ovf32}), 64'(0));
        check("done_ready", 64'(rdy32), 64'(1));

        run32(1'b1, 32'hFFFF_FFF9, 32'd2, edges, va);
        check("s-7_2_quot", 64'(quot32), 64'(32'hFFFF_FFFD));
        check("s-7_2_rem", 64'(rem32), 64'(32'hFFFF_FFFF));
        check("b2b_valid_drop", 64'(va), 64'(0));

        run32(1'b1, 32'd7, 32'hFFFF_FFFE, edges, va);
        check("s7_-2_quot", 64'(quot32), 64'(32'hFFFF_FFFD));
        check("s7_-2_rem", 64'(rem32), 64'(1));

        run32(1'b0, 32'h0000_1234, 32'd0, edges, va);
        check("div0_lat", 64'(edges), 64'(1));
        check("div0_flag", 64'({div0_32, ovf32}), 64'(2'b10));
        check("div0_quot", 64'(quot32), 64'(32'hFFFF_FFFF));
        check("div0_rem", 64'(rem32), 64'(32'h1234));

        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, va);
        check("ovf_lat", 64'(edges), 64'(1));
        check("ovf_flag", 64'({div0_32, ovf32}), 64'(2'b01));
        check("ovf_quot", 64'(quot32), 64'(32'h8000_0000));
        check("ovf_rem", 64'(rem32), 64'(0));

        run32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, edges, va);
        check("umin_quot", 64'(quot32), 64'(0));
        check("umin_rem", 64'(rem32), 64'(32'h8000_0000));
        check("umin_flags", 64'({div0_32, ovf32}), 64'(0));

        run32(1'b1, 32'hFFFF_FF9C, 32'd7, edges, va);
        check("s-100_7_quot", 64'(quot32), 64'(32'hFFFF_FFF2));
        check("s-100_7_rem", 64'(rem32), 64'(32'hFFFF_FFFE));

        // Start held high while busy must not disturb the operation in flight.
        sop32 = 1'b0; dvd32 = 32'd100; dvs32 = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        dvd32 = 32'd50; dvs32 = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        check("busy_ready", 64'(rdy32), 64'(0));
        check("busy_busy", 64'(busy32), 64'(1));
        start32 = 1'b0;
        edges = 0;
        while (!valid32 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check("held_quot", 64'(quot32), 64'(14));
        check("held_rem", 64'(rem32), 64'(2));

        // Reset in the middle of CALC aborts with no result.
        sop32 = 1'b0; dvd32 = 32'd1000; dvs32 = 32'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_valid", 64'(valid32), 64'(0));
        check("abort_ready", 64'(rdy32), 64'(1));
        check("abort_busy", 64'(busy32), 64'(0));
        repeat (40) @(posedge clk);
        #1;
        check("abort_stays_idle", 64'(valid32), 64'(0));

        run8(1'b1, 8'h80, 8'hFF);
        run8(1'b0, 8'h80, 8'hFF);
        run8(1'b1, 8'h05, 8'h00);
        run8(1'b0, 8'hFF, 8'h01);
        run8(1'b1, 8'h80, 8'h01);
        run8(1'b1, 8'h81, 8'h7F);
        run8(1'b0, 8'hC8, 8'h0D);
        run8(1'b1, 8'hC8, 8'h0D);
        for (int i = 0; i < 60; i++)
            run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
